// File: rtl/byte_host_interface.sv
// Host packet engine: parses RX byte packets into wishbone-master commands and serialises responses to TX bytes.
// Define BYTE_HOST_INTERFACE_TIMEOUT_EN to build the inter-byte timeout; otherwise err_timeout is tied low.
module byte_host_interface #(
   parameter int         DATA_WIDTH     = 32,
   parameter int         ADDR_WIDTH     = 32,
   parameter logic [7:0] RX_ID          = 8'hCD,
   parameter logic [7:0] TX_ID          = 8'hDC,
   parameter int         TIMEOUT_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_empty,
   output logic                  rx_rd,
   input  logic [7:0]            rx_data,
   output logic                  rx_flush,
   input  logic                  tx_full,
   output logic                  tx_wr,
   output logic [7:0]            tx_data,
   input  logic                  master_ready,
   output logic                  ih_ready,
   output logic [31:0]           in_command,
   output logic [ADDR_WIDTH-1:0] in_address,
   output logic [27:0]           in_data_count,
   output logic [DATA_WIDTH-1:0] in_data,
   output logic                  oh_ready,
   input  logic                  oh_en,
   input  logic [31:0]           out_status,
   input  logic [ADDR_WIDTH-1:0] out_address,
   input  logic [27:0]           out_data_count,
   input  logic [DATA_WIDTH-1:0] out_data,
   output logic                  err_bad_id,
   output logic                  err_cmd,
   output logic                  err_timeout
);

   localparam int AB = ADDR_WIDTH / 8;
   localparam int DB = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      RX_IDLE, RX_GET_ID, RX_GET_CMD, RX_GET_ADDR, RX_GET_DATA, RX_NOTIFY, RX_FLUSH
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_SEND_ID, TX_SEND_STATUS, TX_SEND_ADDR, TX_SEND_DATA, TX_WAIT_MASTER
   } tx_state_t;

   // ---------------- RX side ----------------
   rx_state_t             r_rx_st;
   logic                  r_rx_rd, r_rd_d, r_rx_flush, r_fcnt;
   logic                  r_ih_ready, r_err_bad_id, r_err_cmd, r_is_wr, r_dec;
   logic [2:0]            r_bcnt;
   logic [23:0]           r_cshift;
   logic [31:0]           r_in_command;
   logic [ADDR_WIDTH-1:0] r_in_address;
   logic [27:0]           r_in_data_count;
   logic [DATA_WIDTH-1:0] r_in_data;

   logic [31:0] w_c;
   logic [23:0] w_n;
   logic        w_get, w_no_rd;
   assign w_c     = {r_cshift, rx_data};
   assign w_n     = (w_c[23:0] == 24'd0) ? 24'd1 : w_c[23:0];
   assign w_get   = (r_rx_st == RX_GET_CMD) || (r_rx_st == RX_GET_ADDR) || (r_rx_st == RX_GET_DATA);
   assign w_no_rd = !r_rx_rd && !r_rd_d;

`ifdef BYTE_HOST_INTERFACE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_err_to;
   assign err_timeout = r_err_to;
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rx_st         <= RX_IDLE;
         r_rx_rd         <= 1'b0;
         r_rd_d          <= 1'b0;
         r_rx_flush      <= 1'b0;
         r_fcnt          <= 1'b0;
         r_ih_ready      <= 1'b0;
         r_err_bad_id    <= 1'b0;
         r_err_cmd       <= 1'b0;
         r_is_wr         <= 1'b0;
         r_dec           <= 1'b0;
         r_bcnt          <= 3'd0;
         r_cshift        <= 24'd0;
         r_in_command    <= 32'd0;
         r_in_address    <= '0;
         r_in_data_count <= 28'd0;
         r_in_data       <= '0;
`ifdef BYTE_HOST_INTERFACE_TIMEOUT_EN
         r_to_cnt        <= '0;
         r_err_to        <= 1'b0;
`endif
      end else begin
         r_rx_rd      <= 1'b0;
         r_rd_d       <= r_rx_rd;
         r_ih_ready   <= 1'b0;
         r_err_bad_id <= 1'b0;
         r_err_cmd    <= 1'b0;
`ifdef BYTE_HOST_INTERFACE_TIMEOUT_EN
         r_err_to     <= 1'b0;
`endif
         // Deferred so the ih_ready cycle still shows the count of the word being handed over
         if (r_dec) begin
            r_in_data_count <= r_in_data_count - 28'd1;
            r_dec           <= 1'b0;
         end
         if (w_get && w_no_rd) begin
            if (!rx_empty) begin
               r_rx_rd <= 1'b1;
`ifdef BYTE_HOST_INTERFACE_TIMEOUT_EN
               r_to_cnt <= '0;
            end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               r_err_to   <= 1'b1;
               r_to_cnt   <= '0;
               r_rx_flush <= 1'b1;
               r_fcnt     <= 1'b0;
               r_rx_st    <= RX_FLUSH;
            end else begin
               r_to_cnt <= r_to_cnt + 1'b1;
`endif
            end
         end
         case (r_rx_st)
            RX_IDLE: if (!rx_empty) begin
               r_rx_rd <= 1'b1;
               r_rx_st <= RX_GET_ID;
            end
            RX_GET_ID: if (r_rd_d) begin
               r_bcnt <= 3'd0;
               if (rx_data == RX_ID) r_rx_st <= RX_GET_CMD;
               else begin
                  r_err_bad_id <= 1'b1;
                  r_rx_flush   <= 1'b1;
                  r_fcnt       <= 1'b0;
                  r_rx_st      <= RX_FLUSH;
               end
            end
            RX_GET_CMD: if (r_rd_d) begin
               r_cshift <= {r_cshift[15:0], rx_data};
               if (r_bcnt == 3'd3) begin
                  r_bcnt       <= 3'd0;
                  r_in_command <= {12'h0, w_c[31:28], 12'h0, w_c[27:24]};
                  case (w_c[27:24])
                     4'd0: begin
                        r_is_wr         <= 1'b0;
                        r_in_data_count <= 28'd0;
                        r_rx_st         <= RX_NOTIFY;
                     end
                     4'd1: begin
                        r_is_wr         <= 1'b1;
                        r_in_data_count <= {4'h0, w_n - 24'd1};
                        r_rx_st         <= RX_GET_ADDR;
                     end
                     4'd2: begin
                        r_is_wr         <= 1'b0;
                        r_in_data_count <= {4'h0, w_c[23:0]};
                        r_rx_st         <= RX_GET_ADDR;
                     end
                     default: begin
                        r_err_cmd  <= 1'b1;
                        r_rx_flush <= 1'b1;
                        r_fcnt     <= 1'b0;
                        r_rx_st    <= RX_FLUSH;
                     end
                  endcase
               end else r_bcnt <= r_bcnt + 3'd1;
            end
            RX_GET_ADDR: if (r_rd_d) begin
               r_in_address <= ADDR_WIDTH'({r_in_address, rx_data});
               if (r_bcnt == 3'(AB - 1)) begin
                  r_bcnt  <= 3'd0;
                  r_rx_st <= r_is_wr ? RX_GET_DATA : RX_NOTIFY;
               end else r_bcnt <= r_bcnt + 3'd1;
            end
            RX_GET_DATA: if (r_rd_d) begin
               r_in_data <= DATA_WIDTH'({r_in_data, rx_data});
               if (r_bcnt == 3'(DB - 1)) begin
                  r_bcnt  <= 3'd0;
                  r_rx_st <= RX_NOTIFY;
               end else r_bcnt <= r_bcnt + 3'd1;
            end
            RX_NOTIFY: if (master_ready) begin
               r_ih_ready <= 1'b1;
               if (r_is_wr && (r_in_data_count != 28'd0)) begin
                  r_dec   <= 1'b1;
                  r_rx_st <= RX_GET_DATA;
               end else r_rx_st <= RX_IDLE;
            end
            RX_FLUSH: begin
               if (r_fcnt) begin
                  r_rx_flush <= 1'b0;
                  r_rx_st    <= RX_IDLE;
               end
               r_fcnt <= 1'b1;
            end
            default: r_rx_st <= RX_IDLE;
         endcase
      end
   end

   assign rx_rd         = r_rx_rd;
   assign rx_flush      = r_rx_flush;
   assign ih_ready      = r_ih_ready;
   assign in_command    = r_in_command;
   assign in_address    = r_in_address;
   assign in_data_count = r_in_data_count;
   assign in_data       = r_in_data;
   assign err_bad_id    = r_err_bad_id;
   assign err_cmd       = r_err_cmd;

   // ---------------- TX side ----------------
   tx_state_t             r_tx_st;
   logic                  r_oh_ready;
   logic [2:0]            r_tidx;
   logic [31:0]           r_s;
   logic [3:0]            r_tstat;
   logic [ADDR_WIDTH-1:0] r_taddr;
   logic [DATA_WIDTH-1:0] r_tdata;
   logic [27:0]           r_tcnt;

   logic       w_sending, w_tx_adv;
   logic [7:0] w_tx_byte;

   always_comb begin
      w_sending = 1'b1;
      w_tx_byte = 8'h00;
      case (r_tx_st)
         TX_SEND_ID:     w_tx_byte = TX_ID;
         TX_SEND_STATUS: w_tx_byte = 8'(r_s >> (8 * (3 - int'(r_tidx))));
         TX_SEND_ADDR:   w_tx_byte = 8'(r_taddr >> (8 * (AB - 1 - int'(r_tidx))));
         TX_SEND_DATA:   w_tx_byte = 8'(r_tdata >> (8 * (DB - 1 - int'(r_tidx))));
         default:        w_sending = 1'b0;
      endcase
   end

   // tx_wr must see this cycle's tx_full, so it is gated combinationally
   assign w_tx_adv = w_sending && !tx_full;
   assign tx_wr    = w_tx_adv;
   assign tx_data  = w_tx_byte;
   assign oh_ready = r_oh_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tx_st    <= TX_IDLE;
         r_oh_ready <= 1'b0;
         r_tidx     <= 3'd0;
         r_s        <= 32'd0;
         r_tstat    <= 4'd0;
         r_taddr    <= '0;
         r_tdata    <= '0;
         r_tcnt     <= 28'd0;
      end else begin
         case (r_tx_st)
            TX_IDLE: begin
               r_oh_ready <= 1'b1;
               if (r_oh_ready && oh_en) begin
                  r_s        <= (out_status[3:0] == 4'hF) ? {out_status[7:0], 24'h0}
                                : {out_status[7:0], out_data_count[23:0] + 24'd1};
                  r_tstat    <= out_status[3:0];
                  r_taddr    <= out_address;
                  r_tdata    <= out_data;
                  r_tcnt     <= out_data_count;
                  r_tidx     <= 3'd0;
                  r_oh_ready <= 1'b0;
                  r_tx_st    <= TX_SEND_ID;
               end
            end
            TX_SEND_ID: if (w_tx_adv) r_tx_st <= TX_SEND_STATUS;
            TX_SEND_STATUS: if (w_tx_adv) begin
               if (r_tidx == 3'd3) begin
                  r_tidx <= 3'd0;
                  if (r_tstat == 4'hF) begin
                     r_oh_ready <= 1'b1;
                     r_tx_st    <= TX_IDLE;
                  end else r_tx_st <= TX_SEND_ADDR;
               end else r_tidx <= r_tidx + 3'd1;
            end
            TX_SEND_ADDR: if (w_tx_adv) begin
               if (r_tidx == 3'(AB - 1)) begin
                  r_tidx <= 3'd0;
                  if (r_tstat == 4'hD) r_tx_st <= TX_SEND_DATA;
                  else begin
                     r_oh_ready <= 1'b1;
                     r_tx_st    <= TX_IDLE;
                  end
               end else r_tidx <= r_tidx + 3'd1;
            end
            TX_SEND_DATA: if (w_tx_adv) begin
               if (r_tidx == 3'(DB - 1)) begin
                  r_tidx     <= 3'd0;
                  r_oh_ready <= 1'b1;
                  if (r_tcnt != 28'd0) begin
                     r_tcnt  <= r_tcnt - 28'd1;
                     r_tx_st <= TX_WAIT_MASTER;
                  end else r_tx_st <= TX_IDLE;
               end else r_tidx <= r_tidx + 3'd1;
            end
            TX_WAIT_MASTER: if (oh_en) begin
               r_tdata    <= out_data;
               r_oh_ready <= 1'b0;
               r_tx_st    <= TX_SEND_DATA;
            end
            default: r_tx_st <= TX_IDLE;
         endcase
      end
   end

   logic w_unused;
   assign w_unused = ^{out_status[31:8], out_data_count[27:24], (TIMEOUT_CYCLES != 0)};

endmodule

// File: tb/tb_byte_host_interface.sv
// Directed bench for byte_host_interface: FIFO models on both sides, scoreboard queues for ih_ready and TX bytes.
module tb_byte_host_interface;
   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk = 1'b0, rst = 1'b0;
   logic          rx_empty = 1'b1, rx_rd, rx_flush;
   logic [7:0]    rx_data = 8'h00;
   logic          tx_full = 1'b0, tx_wr;
   logic [7:0]    tx_data;
   logic          master_ready = 1'b1, ih_ready;
   logic [31:0]   in_command;
   logic [AW-1:0] in_address;
   logic [27:0]   in_data_count;
   logic [DW-1:0] in_data;
   logic          oh_ready, oh_en = 1'b0;
   logic [31:0]   out_status = '0;
   logic [AW-1:0] out_address = '0;
   logic [27:0]   out_data_count = '0;
   logic [DW-1:0] out_data = '0;
   logic          err_bad_id, err_cmd, err_timeout;

   byte_host_interface #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RX_ID(8'hCD), .TX_ID(8'hDC), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_rd(rx_rd), .rx_data(rx_data),
      .rx_flush(rx_flush), .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
      .master_ready(master_ready), .ih_ready(ih_ready), .in_command(in_command),
      .in_address(in_address), .in_data_count(in_data_count), .in_data(in_data),
      .oh_ready(oh_ready), .oh_en(oh_en), .out_status(out_status), .out_address(out_address),
      .out_data_count(out_data_count), .out_data(out_data), .err_bad_id(err_bad_id),
      .err_cmd(err_cmd), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   cmd;
      logic [AW-1:0] addr;
      logic [27:0]   cnt;
      logic [DW-1:0] data;
   } ih_t;

   ih_t        ihq[$];
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   ih_t        ih_e;
   logic [7:0] tx_e;
   int g_checks = 0, g_fails = 0;
   int n_flush = 0, n_bad = 0, n_cmd = 0, n_to = 0;
   bit tog_en = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      g_checks++;
      assert (obs === exp) else begin
         g_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // RX FIFO model: byte valid the cycle after rx_rd, flush empties it
   always @(posedge clk) begin
      if (rx_flush) rxq.delete();
      else if (rx_rd && rxq.size() != 0) rx_data <= rxq.pop_front();
   end
   always @(negedge clk) rx_empty <= (rxq.size() == 0);

   // TX backpressure changes just after the active edge
   always @(posedge clk) begin
      #2;
      if (tog_en) tx_full = ~tx_full;
      else tx_full = 1'b0;
   end

   always @(negedge clk) begin
      if (rx_flush) n_flush++;
      if (err_bad_id) n_bad++;
      if (err_cmd) n_cmd++;
      if (err_timeout) n_to++;
      if (rx_rd) chk("rd_nonempty", 64'(rxq.size() != 0), 64'd1);
      if (tx_full) chk("tx_wr_full", 64'(tx_wr), 64'd0);
      if (tx_wr && !tx_full) begin
         if (txq.size() == 0) chk("tx_unexp", 64'(txq.size()), 64'd1);
         else begin
            tx_e = txq.pop_front();
            chk("tx_byte", 64'(tx_data), 64'(tx_e));
         end
      end
      if (ih_ready) begin
         if (ihq.size() == 0) chk("ih_unexp", 64'(ihq.size()), 64'd1);
         else begin
            ih_e = ihq.pop_front();
            chk("ih_cmd", 64'(in_command), 64'(ih_e.cmd));
            chk("ih_addr", 64'(in_address), 64'(ih_e.addr));
            chk("ih_cnt", 64'(in_data_count), 64'(ih_e.cnt));
            chk("ih_data", 64'(in_data), 64'(ih_e.data));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_bytes(input logic [63:0] v, input int n);
      @(negedge clk);
      for (int i = n - 1; i >= 0; i--) rxq.push_back(v[8*i +: 8]);
   endtask

   task automatic exp_tx(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) txq.push_back(v[8*i +: 8]);
   endtask

   task automatic exp_ih(input logic [31:0] c, input logic [AW-1:0] a, input logic [27:0] n,
                         input logic [DW-1:0] d);
      ih_t x;
      x.cmd = c; x.addr = a; x.cnt = n; x.data = d;
      ihq.push_back(x);
   endtask

   task automatic wait_ih(input string tag, input int bound);
      int n = 0;
      while (ihq.size() != 0 && n < bound) begin @(negedge clk); n++; end
      chk(tag, 64'(ihq.size()), 64'd0);
   endtask

   task automatic wait_tx(input string tag, input int bound);
      int n = 0;
      while (txq.size() != 0 && n < bound) begin @(negedge clk); n++; end
      chk(tag, 64'(txq.size()), 64'd0);
   endtask

   task automatic send_resp(input logic [31:0] st, input logic [27:0] cnt,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      while (!oh_ready && n < 100) begin @(negedge clk); n++; end
      chk("oh_ready_wait", 64'(oh_ready), 64'd1);
      out_status = st; out_data_count = cnt; out_address = a; out_data = d;
      oh_en = 1'b1;
      @(negedge clk);
      oh_en = 1'b0;
   endtask

   int f0, b0;
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_strobes", 64'({ih_ready, rx_rd, rx_flush, tx_wr, oh_ready, err_bad_id, err_cmd, err_timeout}), 64'd0);
      chk("rst_fields", 64'({in_command, in_data_count}), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("oh_ready_rise", 64'(oh_ready), 64'd1);

      // ping
      f0 = n_flush;
      exp_ih(32'h0, '0, 28'd0, '0);
      push_bytes(64'hCD00000000, 5);
      wait_ih("ping", 200);
      idle(5);
      chk("ping_noflush", 64'(n_flush - f0), 64'd0);

      // two-word write
      exp_ih(32'h1, 32'h100, 28'd1, 32'h11223344);
      exp_ih(32'h1, 32'h100, 28'd0, 32'h55667788);
      push_bytes(64'hCD01000002, 5);
      push_bytes(64'h00000100, 4);
      push_bytes(64'h1122334455667788, 8);
      wait_ih("write2", 400);

      // read with flags, held off by master_ready
      master_ready = 1'b0;
      exp_ih(32'h00050002, 32'h40, 28'd5, 32'h55667788);
      push_bytes(64'hCD52000005, 5);
      push_bytes(64'h00000040, 4);
      idle(60);
      chk("mr_hold", 64'(ihq.size()), 64'd1);
      master_ready = 1'b1;
      wait_ih("read", 100);

      // bad id, then a good ping
      f0 = n_flush; b0 = n_bad;
      push_bytes(64'hAB, 1);
      idle(15);
      chk("bad_id", 64'(n_bad - b0), 64'd1);
      chk("bad_flush", 64'(n_flush - f0), 64'd2);
      exp_ih(32'h0, 32'h40, 28'd0, 32'h55667788);
      push_bytes(64'hCD00000000, 5);
      wait_ih("ping_after_bad", 200);

      // illegal command
      f0 = n_flush; b0 = n_cmd;
      push_bytes(64'hCD07000000, 5);
      idle(30);
      chk("err_cmd", 64'(n_cmd - b0), 64'd1);
      chk("cmd_flush", 64'(n_flush - f0), 64'd2);

      // write with N==0 behaves as one word
      exp_ih(32'h1, 32'h20, 28'd0, 32'hDEADBEEF);
      push_bytes(64'hCD01000000, 5);
      push_bytes(64'h00000020, 4);
      push_bytes(64'hDEADBEEF, 4);
      wait_ih("write_n0", 300);

      // back-to-back pings already queued
      f0 = n_flush;
      exp_ih(32'h0, 32'h20, 28'd0, 32'hDEADBEEF);
      exp_ih(32'h0, 32'h20, 28'd0, 32'hDEADBEEF);
      push_bytes(64'hCD00000000, 5);
      push_bytes(64'hCD00000000, 5);
      wait_ih("b2b", 300);
      chk("b2b_noflush", 64'(n_flush - f0), 64'd0);

`ifdef BYTE_HOST_INTERFACE_TIMEOUT_EN
      f0 = n_flush; b0 = n_to;
      push_bytes(64'hCD02, 2);
      idle(40);
      chk("timeout", 64'(n_to - b0), 64'd1);
      chk("to_flush", 64'(n_flush - f0), 64'd2);
`endif

      // TX read response under toggling backpressure
      tog_en = 1'b1;
      exp_tx(64'hDC0E000001, 5);
      exp_tx(64'h00000010, 4);
      send_resp(32'h0E, 28'd0, 32'h10, 32'h0);
      wait_tx("tx_read", 200);

      // TX two-word data stream
      exp_tx(64'hDC0D000002, 5);
      exp_tx(64'hA0B0C0D0, 4);
      exp_tx(64'h01020304, 4);
      send_resp(32'h0D, 28'd1, 32'hA0B0C0D0, 32'h01020304);
      wait_tx("tx_word0", 300);
      idle(3);
      chk("wait_master_rdy", 64'(oh_ready), 64'd1);
      exp_tx(64'h05060708, 4);
      out_data = 32'h05060708;
      oh_en = 1'b1;
      @(negedge clk);
      oh_en = 1'b0;
      wait_tx("tx_word1", 200);
      idle(10);
      chk("tx_back_idle", 64'(oh_ready), 64'd1);

      // status-only response
      exp_tx(64'hDC3F000000, 5);
      send_resp(32'h3F, 28'd5, 32'h99, 32'h0);
      wait_tx("tx_status_only", 200);
      idle(10);

      // count field wraps mod 2^24
      exp_tx(64'hDC01000000, 5);
      exp_tx(64'h12345678, 4);
      send_resp(32'h01, 28'h0FFFFFF, 32'h12345678, 32'h0);
      wait_tx("tx_wrap", 200);
      idle(10);
      tog_en = 1'b0;

      idle(10);
      $display("End of test - %0d assertions evaluated, %0d failures", g_checks, g_fails);
      $finish;
   end
endmodule
